// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, widths and size helpers for the convolution sequencer
//   conv_state_t : sequencer FSM states
//   FM_W/WT_W/P_W: feature-map pixel, weight lane and PE result widths
//   n_pix/n_out  : pixel count of the feature map, output count of one pass
package conv_pkg;

    localparam int FM_W = 30;
    localparam int WT_W = 18;
    localparam int P_W  = 48;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } conv_state_t;

    function automatic int n_pix(input int fm);
        return fm * fm;
    endfunction

    function automatic int n_out(input int fm, input int k);
        return (fm - k + 1) * (fm - k + 1);
    endfunction

endpackage

// File: rtl/conv_out_writer.sv
// rtl/conv_out_writer.sv - PE result capture into the output buffer with overflow detection
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_clear             : zero the output count (pass start)
//   i_active            : capture window (STREAM/DRAIN)
//   i_valid, i_p        : PE result strobe and value
//   o_wr_en/addr/data   : registered output-buffer write
//   o_complete          : this cycle completes (or has completed) the output set
//   o_ovf               : a valid arrived with the output set already full
module conv_out_writer
    import conv_pkg::*;
#(
    parameter int OUT_ADDR_W = 8,
    parameter int N_OUT      = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_active,
    input  logic                  i_valid,
    input  logic [P_W-1:0]        i_p,
    output logic                  o_wr_en,
    output logic [OUT_ADDR_W-1:0] o_wr_addr,
    output logic [P_W-1:0]        o_wr_data,
    output logic                  o_complete,
    output logic                  o_ovf
);

    // One extra bit so the count can sit at N_OUT without wrapping.
    localparam int CNT_W = OUT_ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_OUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_OUT - 1);

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_en_q, wr_en_d;
    logic [OUT_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [P_W-1:0]        wr_data_q, wr_data_d;
    logic                  accept;

    always_comb begin
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        accept    = 1'b0;
        o_ovf     = 1'b0;
        if (i_clear) begin
            count_d = '0;
        end else if (i_active && i_valid) begin
            if (count_q < CNT_FULL) begin
                accept    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = count_q[OUT_ADDR_W-1:0];
                wr_data_d = i_p;
                count_d   = count_q + CNT_W'(1);
            end else begin
                o_ovf = 1'b1;
            end
        end
    end

    // Completion either on the accepting cycle of the last result, or later if
    // the set filled up early (results arriving while still streaming).
    assign o_complete = i_active && ((accept && (count_q == CNT_LAST)) || (count_q >= CNT_FULL));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - runs one convolution pass on an attached PE
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_start, i_weight            : pass start pulse (IDLE only) and kernel weights
//   o_busy, o_done, o_err        : pass in progress, completion pulse, sticky error
//   o_fm_rd, o_fm_addr, i_fm_data: FM memory read port (data one cycle after read)
//   o_pe_en, o_DataFM, o_Weight  : PE drive
//   i_pe_valid, i_pe_P           : PE result
//   o_wr_en/addr/data            : output-buffer write port
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 2,
    parameter int FM_SIZE     = 4,
    parameter int FM_ADDR_W   = 8,
    parameter int OUT_ADDR_W  = 8,
    parameter int DRAIN_MAX   = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*WT_W-1:0] i_weight,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_err,
    output logic                                  o_fm_rd,
    output logic [FM_ADDR_W-1:0]                  o_fm_addr,
    input  logic [FM_W-1:0]                       i_fm_data,
    output logic                                  o_pe_en,
    output logic [FM_W-1:0]                       o_DataFM,
    output logic [KERNEL_SIZE*KERNEL_SIZE*WT_W-1:0] o_Weight,
    input  logic                                  i_pe_valid,
    input  logic [P_W-1:0]                        i_pe_P,
    output logic                                  o_wr_en,
    output logic [OUT_ADDR_W-1:0]                 o_wr_addr,
    output logic [P_W-1:0]                        o_wr_data
);

    localparam int N_PIX = n_pix(FM_SIZE);
    localparam int N_OUT = n_out(FM_SIZE, KERNEL_SIZE);
    localparam int W_W   = KERNEL_SIZE * KERNEL_SIZE * WT_W;
    localparam int DR_W  = $clog2(DRAIN_MAX + 1);
    localparam logic [FM_ADDR_W-1:0] LAST_ADDR = FM_ADDR_W'(N_PIX - 1);
    localparam logic [DR_W-1:0]      DRAIN_LAST = DR_W'(DRAIN_MAX - 1);

    conv_state_t          state_q, state_d;
    logic [FM_ADDR_W-1:0] addr_q, addr_d;
    logic                 rd_dly_q, rd_dly_d;
    logic                 pe_en_q, pe_en_d;
    logic [FM_W-1:0]      data_fm_q, data_fm_d;
    logic [W_W-1:0]       weight_q, weight_d;
    logic [DR_W-1:0]      drain_q, drain_d;
    logic                 err_q, err_d;

    logic                 start_acc;
    logic                 wr_active;
    logic                 wr_complete;
    logic                 wr_ovf;

    assign wr_active = (state_q == STREAM) || (state_q == DRAIN);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_dly_d  = 1'b0;
        pe_en_d   = 1'b0;
        data_fm_d = '0;
        weight_d  = weight_q;
        drain_d   = drain_q;
        err_d     = err_q | wr_ovf;
        start_acc = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    weight_d  = i_weight;
                    err_d     = 1'b0;
                    addr_d    = '0;
                    drain_d   = '0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                rd_dly_d = 1'b1;
                // The PE enable rises with the first returned pixel and then
                // never drops until DONE, since a low i_en resets the PE.
                pe_en_d   = rd_dly_q;
                data_fm_d = rd_dly_q ? i_fm_data : '0;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + FM_ADDR_W'(1);
                end
            end
            DRAIN: begin
                drain_d = drain_q + DR_W'(1);
                // Completion outranks the timeout when both land together.
                if (wr_complete) begin
                    state_d = DONE;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
                if (state_d != DONE) begin
                    pe_en_d = 1'b1;
                    // First drain cycle still carries the last pixel's data.
                    data_fm_d = rd_dly_q ? i_fm_data : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_dly_q  <= 1'b0;
            pe_en_q   <= 1'b0;
            data_fm_q <= '0;
            weight_q  <= '0;
            drain_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_dly_q  <= rd_dly_d;
            pe_en_q   <= pe_en_d;
            data_fm_q <= data_fm_d;
            weight_q  <= weight_d;
            drain_q   <= drain_d;
            err_q     <= err_d;
        end
    end

    conv_out_writer #(
        .OUT_ADDR_W (OUT_ADDR_W),
        .N_OUT      (N_OUT)
    ) u_out_writer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (start_acc),
        .i_active   (wr_active),
        .i_valid    (i_pe_valid),
        .i_p        (i_pe_P),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_complete (wr_complete),
        .o_ovf      (wr_ovf)
    );

    assign o_busy    = (state_q != IDLE);
    assign o_done    = (state_q == DONE);
    assign o_err     = err_q;
    assign o_fm_rd   = (state_q == STREAM);
    assign o_fm_addr = addr_q;
    assign o_pe_en   = pe_en_q;
    assign o_DataFM  = data_fm_q;
    assign o_Weight  = weight_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - directed self-checking bench for conv_sequencer
module tb_conv_sequencer;

    localparam int MAXC = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start_a, start_b, pe_valid;
    logic [29:0]  fm_data;
    logic [47:0]  pe_p;
    logic [71:0]  weight_a;
    logic [161:0] weight_b;

    logic a_busy, a_done, a_err, a_fm_rd, a_pe_en, a_wr_en;
    logic [7:0] a_fm_addr, a_wr_addr;
    logic [29:0] a_datafm;
    logic [71:0] a_weight;
    logic [47:0] a_wr_data;

    logic b_busy, b_done, b_err, b_fm_rd, b_pe_en, b_wr_en;
    logic [7:0] b_fm_addr, b_wr_addr;
    logic [29:0] b_datafm;
    logic [161:0] b_weight;
    logic [47:0] b_wr_data;

    conv_sequencer #(.KERNEL_SIZE(2), .FM_SIZE(4), .FM_ADDR_W(8), .OUT_ADDR_W(8), .DRAIN_MAX(32)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_weight(weight_a),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err),
        .o_fm_rd(a_fm_rd), .o_fm_addr(a_fm_addr), .i_fm_data(fm_data),
        .o_pe_en(a_pe_en), .o_DataFM(a_datafm), .o_Weight(a_weight),
        .i_pe_valid(pe_valid), .i_pe_P(pe_p),
        .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data));

    conv_sequencer #(.KERNEL_SIZE(3), .FM_SIZE(3), .FM_ADDR_W(8), .OUT_ADDR_W(8), .DRAIN_MAX(32)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_weight(weight_b),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err),
        .o_fm_rd(b_fm_rd), .o_fm_addr(b_fm_addr), .i_fm_data(fm_data),
        .o_pe_en(b_pe_en), .o_DataFM(b_datafm), .o_Weight(b_weight),
        .i_pe_valid(pe_valid), .i_pe_P(pe_p),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data));

    int sel;
    wire         m_busy    = (sel == 1) ? b_busy    : a_busy;
    wire         m_done    = (sel == 1) ? b_done    : a_done;
    wire         m_err     = (sel == 1) ? b_err     : a_err;
    wire         m_fm_rd   = (sel == 1) ? b_fm_rd   : a_fm_rd;
    wire [7:0]   m_fm_addr = (sel == 1) ? b_fm_addr : a_fm_addr;
    wire         m_pe_en   = (sel == 1) ? b_pe_en   : a_pe_en;
    wire [29:0]  m_datafm  = (sel == 1) ? b_datafm  : a_datafm;
    wire [161:0] m_weight  = (sel == 1) ? b_weight  : {90'b0, a_weight};
    wire         m_wr_en   = (sel == 1) ? b_wr_en   : a_wr_en;
    wire [7:0]   m_wr_addr = (sel == 1) ? b_wr_addr : a_wr_addr;
    wire [47:0]  m_wr_data = (sel == 1) ? b_wr_data : a_wr_data;
    wire [282:0] m_outs = {m_busy, m_done, m_err, m_fm_rd, m_fm_addr, m_pe_en, m_datafm,
                           m_weight, m_wr_en, m_wr_addr, m_wr_data};

    int n_tot = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic valid_at[128];
    int rd_addr[128], rd_cyc[128], wr_addr[128], wr_cyc[128];
    logic [47:0] wr_data[128];
    logic [29:0] datafm_at[128];
    int n_rd, n_wr, n_done, done_cyc, pe_first, pe_last, pe_cnt;
    int busy_after, err_at_done, err_after, err_c1, err_c11, err_c12;
    logic [161:0] wt_c1;
    logic [282:0] outs_c8;

    task automatic set_valid(input int from, input int to);
        for (int i = 0; i < 128; i++) valid_at[i] = (i >= from) && (i <= to);
    endtask

    task automatic run_pass(input int which, input int extra_start, input int rst_at);
        logic prev_rd;
        int   prev_addr;
        n_rd = 0; n_wr = 0; n_done = 0; done_cyc = -1;
        pe_first = -1; pe_last = -1; pe_cnt = 0;
        busy_after = -1; err_at_done = -1; err_after = -1;
        err_c1 = -1; err_c11 = -1; err_c12 = -1; wt_c1 = '0; outs_c8 = '1;
        sel = which;
        prev_rd = 1'b0; prev_addr = 0;
        @(posedge clk); #1;
        for (int rel = 0; rel < MAXC; rel++) begin
            start_a  = (which == 0) && (rel == 0 || rel == extra_start);
            start_b  = (which == 1) && (rel == 0 || rel == extra_start);
            rst      = (rel == rst_at);
            pe_valid = valid_at[rel];
            pe_p     = 48'(1000 + rel);
            fm_data  = prev_rd ? 30'(prev_addr + 1) : 30'h0;
            @(negedge clk);
            datafm_at[rel] = m_datafm;
            if (m_fm_rd) begin
                rd_addr[n_rd] = int'(m_fm_addr); rd_cyc[n_rd] = rel; n_rd++;
            end
            if (m_wr_en) begin
                wr_addr[n_wr] = int'(m_wr_addr); wr_data[n_wr] = m_wr_data; wr_cyc[n_wr] = rel; n_wr++;
            end
            if (m_pe_en) begin
                if (pe_first < 0) pe_first = rel;
                pe_last = rel; pe_cnt++;
            end
            if (m_done) begin
                n_done++; done_cyc = rel; err_at_done = int'(m_err);
            end
            if (rel == 1) begin err_c1 = int'(m_err); wt_c1 = m_weight; end
            if (rel == 8) outs_c8 = m_outs;
            if (rel == 11) err_c11 = int'(m_err);
            if (rel == 12) err_c12 = int'(m_err);
            prev_rd = m_fm_rd; prev_addr = int'(m_fm_addr);
            if (done_cyc >= 0 && rel == done_cyc + 1) begin
                busy_after = int'(m_busy); err_after = int'(m_err);
                break;
            end
            @(posedge clk); #1;
        end
        start_a = 1'b0; start_b = 1'b0; rst = 1'b0; pe_valid = 1'b0;
    endtask

    // K=2, FM=4 pass with valids in cycles 20..28: 16 reads, 9 writes, done at 29.
    task automatic check_full_a(input string tag);
        check_eq({tag, " n_rd"}, n_rd, 16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("%s rd_addr%0d", tag, i), rd_addr[i], i);
            check_eq($sformatf("%s rd_cyc%0d", tag, i), rd_cyc[i], 1 + i);
        end
        check_eq({tag, " n_wr"}, n_wr, 9);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("%s wr_addr%0d", tag, i), wr_addr[i], i);
            check_eq($sformatf("%s wr_data%0d", tag, i), wr_data[i], 1020 + i);
            check_eq($sformatf("%s wr_cyc%0d", tag, i), wr_cyc[i], 21 + i);
        end
        check_eq({tag, " n_done"}, n_done, 1);
        check_eq({tag, " done_cyc"}, done_cyc, 29);
        check_eq({tag, " err"}, err_at_done, 0);
        check_eq({tag, " busy_after"}, busy_after, 0);
        check_eq({tag, " pe_first"}, pe_first, 3);
        check_eq({tag, " pe_last"}, pe_last, 28);
        check_eq({tag, " pe_cnt"}, pe_cnt, 26);
    endtask

    logic [161:0] exp_wa, exp_wb;

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; pe_valid = 1'b0;
        pe_p = '0; fm_data = '0; sel = 0;
        weight_a = '0; weight_b = '0;
        for (int i = 0; i < 4; i++) weight_a[i*18 +: 18] = 18'd1;
        for (int i = 0; i < 9; i++) weight_b[i*18 +: 18] = 18'(i + 1);
        exp_wa = 162'h0;
        for (int i = 0; i < 4; i++) exp_wa = exp_wa | (162'(1) << (i * 18));
        exp_wb = 162'h0;
        for (int i = 0; i < 9; i++) exp_wb = exp_wb | (162'(i + 1) << (i * 18));
        set_valid(-1, -1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_a", {a_busy, a_done, a_err, a_fm_rd, a_fm_addr, a_pe_en, a_datafm,
                             a_weight, a_wr_en, a_wr_addr, a_wr_data}, '0);
        check_eq("reset_b", {b_busy, b_done, b_err, b_fm_rd, b_fm_addr, b_pe_en, b_datafm,
                             b_weight, b_wr_en, b_wr_addr, b_wr_data}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // normal pass, K=2 FM=4
        set_valid(20, 28);
        run_pass(0, -1, -1);
        check_full_a("normal");
        for (int p = 0; p < 16; p++)
            check_eq($sformatf("normal datafm%0d", p), datafm_at[3 + p], p + 1);
        check_eq("normal datafm_drain", datafm_at[19], 0);
        check_eq("normal weight", wt_c1, exp_wa);

        // K=3 FM=3: one output
        set_valid(13, 13);
        run_pass(1, -1, -1);
        check_eq("k3 n_rd", n_rd, 9);
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("k3 rd_addr%0d", i), rd_addr[i], i);
        check_eq("k3 n_wr", n_wr, 1);
        check_eq("k3 wr_addr", wr_addr[0], 0);
        check_eq("k3 wr_data", wr_data[0], 1013);
        check_eq("k3 done_cyc", done_cyc, 14);
        check_eq("k3 busy_after", busy_after, 0);
        check_eq("k3 err", err_at_done, 0);
        check_eq("k3 pe_last", pe_last, 13);
        check_eq("k3 weight", wt_c1, exp_wb);

        // second start during the pass is ignored
        set_valid(20, 28);
        run_pass(0, 5, -1);
        check_full_a("restart");

        // no valids: timeout 32 cycles after DRAIN entry (cycle 17)
        set_valid(-1, -1);
        run_pass(0, -1, -1);
        check_eq("tmo done_cyc", done_cyc, 49);
        check_eq("tmo err", err_at_done, 1);
        check_eq("tmo err_sticky", err_after, 1);
        check_eq("tmo n_wr", n_wr, 0);
        check_eq("tmo pe_last", pe_last, 48);

        // 10 valids while streaming: 9 written, 10th flags overflow
        set_valid(2, 11);
        run_pass(0, -1, -1);
        check_eq("ovf err_cleared", err_c1, 0);
        check_eq("ovf n_wr", n_wr, 9);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("ovf wr_addr%0d", i), wr_addr[i], i);
            check_eq($sformatf("ovf wr_data%0d", i), wr_data[i], 1002 + i);
        end
        check_eq("ovf err_c11", err_c11, 0);
        check_eq("ovf err_c12", err_c12, 1);
        check_eq("ovf done_cyc", done_cyc, 18);

        // reset in cycle 7 aborts the pass
        set_valid(20, 28);
        run_pass(0, -1, 7);
        check_eq("rst outs_c8", outs_c8, '0);
        check_eq("rst n_done", n_done, 0);
        check_eq("rst n_rd", n_rd, 7);
        check_eq("rst n_wr", n_wr, 0);

        // full pass after the abort
        run_pass(0, -1, -1);
        check_full_a("after_rst");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Controller that runs one convolution pass on the DSP-cascade `PE` array. It latches the kernel weights and streams the feature map row-major from a synchronous FM memory into `PE`, holding the PE enable continuously for the whole pass. It collects the PE's valid outputs into an output buffer and signals completion. It sits between the FM/weight storage and the `PE` instance, one sequencer per PE.

## Interface
- `KERNEL_SIZE`, 2: kernel side; must match the attached `PE`.
- `FM_SIZE`, 4: feature-map side; must satisfy `FM_SIZE >= KERNEL_SIZE`.
- `FM_ADDR_W`, 8: FM address width; must satisfy `2^FM_ADDR_W >= FM_SIZE^2`.
- `OUT_ADDR_W`, 8: output-buffer address width.
- `DRAIN_MAX`, 32: maximum drain cycles after the last pixel before an error is flagged.

Ports (name, direction, width, meaning):
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: single-cycle pulse that starts a pass; sampled only in IDLE.
- `i_weight` in K·K·18: kernel weights; latched when a start is accepted.
- `o_busy` out 1: high from start acceptance until DONE is left.
- `o_done` out 1: one-cycle pulse when a pass completes.
- `o_err` out 1: sticky drain-timeout / overflow flag; cleared by `i_rst` or the next accepted start.
- `o_fm_rd` out 1: FM memory read strobe.
- `o_fm_addr` out FM_ADDR_W: FM read address, row-major.
- `i_fm_data` in 30: FM read data, valid one cycle after `o_fm_rd`.
- `o_pe_en` out 1: drives `PE.i_en`.
- `o_DataFM` out 30: drives `PE.i_DataFM`.
- `o_Weight` out K·K·18: drives `PE.i_Weight`.
- `i_pe_valid` in 1: from `PE.o_en`.
- `i_pe_P` in 48: from `PE.o_P`.
- `o_wr_en` out 1: output-buffer write strobe.
- `o_wr_addr` out OUT_ADDR_W: output-buffer write address.
- `o_wr_data` out 48: output-buffer write data.

## Operation
- Constants: `N_PIX = FM_SIZE²`; `OUT_DIM = FM_SIZE−KERNEL_SIZE+1`; `N_OUT = OUT_DIM²`.
- FSM states: IDLE → STREAM → DRAIN → DONE → IDLE.
- **IDLE**: on `i_start`, latch `i_weight` into `o_Weight`, clear `o_err` and all counters, go to STREAM. `i_start` in any other state is ignored.
- **STREAM**: assert `o_fm_rd` each cycle with `o_fm_addr` = 0..N_PIX−1. After issuing address N_PIX−1, go to DRAIN.
- **Data path**: each read returns in the next cycle and is registered into `o_DataFM`, with `o_pe_en` set in the same register stage.
- **DRAIN**: hold `o_pe_en`=1 with `o_DataFM`=0 so the PE pipeline flushes, because the PE resets its counters whenever `i_en` is low.
  - Go to DONE when the output count reaches N_OUT.
  - If the drain-cycle count reaches DRAIN_MAX first, set `o_err` and go to DONE.
- **Output capture**: in STREAM and DRAIN, every cycle with `i_pe_valid`=1 registers `i_pe_P` into `o_wr_data`, pulses `o_wr_en`, uses the current output count as `o_wr_addr`, then increments the count.
  - Valids arriving once the count equals N_OUT are not written and set `o_err`.
  - Valids in IDLE and DONE are ignored.
- **DONE**: for one cycle, `o_pe_en`=0 and `o_done`=1; then return to IDLE. `o_busy` drops in the same cycle the state returns to IDLE.
- `o_Weight` holds its value outside of start acceptance.

## Timing
- Reset values: all outputs 0; state IDLE; all counters 0.
- `i_rst` mid-pass aborts the pass the next cycle: `o_pe_en` 0 and no `o_done` pulse.
- Cycle numbering, with `i_start` high in cycle 0:
  - Cycle 1: `o_busy`=1, `o_fm_rd`=1, `o_fm_addr`=0.
  - Pixel p is read in cycle 1+p and appears on `o_DataFM` in cycle 3+p, with `o_pe_en`=1 from cycle 3.
  - Last read is in cycle N_PIX; DRAIN starts in cycle N_PIX+1.
- `o_pe_en` has no gaps from cycle 3 until DONE.
- Write latency: `i_pe_valid` in cycle t produces `o_wr_en` in cycle t+1.
- The N_OUT-th valid, in cycle t, produces DONE and `o_done` in cycle t+1, coinciding with the last `o_wr_en`.
- If a valid and the DRAIN_MAX timeout occur in the same cycle, the valid is written and the normal completion takes priority (no `o_err` if the count completes).
- `KERNEL_SIZE == FM_SIZE` is legal: N_OUT = 1.

## Structure
- Shared package `conv_pkg`:
  - state enum `conv_state_t` (IDLE, STREAM, DRAIN, DONE);
  - constant functions `n_pix(FM)` and `n_out(FM,K)`;
  - the widths 30 (FM) / 18 (weight) / 48 (P).
- One natural sub-module, `conv_out_writer`: the output-capture counter, write register and overflow check. FSM and read addressing stay in `conv_sequencer`.

## Test plan
- K=2, FM=4, FM memory holds pixel values 1..16, weights all 1, real `PE` attached → `o_pe_en` continuous from cycle 3; exactly 9 writes to addresses 0..8; `o_done` pulse one cycle after the 9th valid; `o_err`=0.
- K=3, FM=3 → 9 reads at addresses 0..8, exactly 1 write at address 0, `o_done` pulse, `o_busy` then 0.
- Second `i_start` pulsed in cycle 5 of a pass → ignored; address sequence and write count unchanged.
- Stubbed PE that never asserts valid, DRAIN_MAX=32 → DONE exactly 32 cycles after DRAIN entry, `o_err`=1, 0 writes; the next start clears `o_err`.
- Stubbed PE asserting 10 valids with K=2, FM=4 → 9 writes, 10th suppressed, `o_err`=1.
- `i_rst` asserted in cycle 7 of a pass → the next cycle shows all outputs 0 and state IDLE, no `o_done`; a new start runs a full correct pass.
